bsg_lfsr_checker: RTL and testbench

- Downstream consumer of the free-running Galois LFSR word stream.
- Self-seeds from the first accepted non-zero word, then predicts every following word and compares it against what arrives.
- Counts mismatches and words, and reports lock status.
- Used in BIST and link-test benches to validate pseudo-random traffic end to end.

---
 rtl/bsg_lfsr_checker_pkg.sv | 21 ++
 rtl/bsg_lfsr_checker_if.sv | 11 +
 rtl/bsg_lfsr_checker_step.sv | 20 ++
 rtl/bsg_lfsr_checker.sv | 140 ++++++++++++++
 tb/tb_bsg_lfsr_checker.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/bsg_lfsr_checker_pkg.sv
// Shared types, constants and the LFSR step helper for the LFSR word checker.
package bsg_lfsr_checker_pkg;

    // SEED: waiting for a legal (non-zero) word to seed the predictor.
    // CHECK: predicting and comparing every accepted word.
    typedef enum logic {
        SEED  = 1'b0,
        CHECK = 1'b1
    } state_e;

    // Feedback mask matching the 32-bit upstream Galois LFSR (taps 31, 29, 26, 25).
    localparam logic [31:0] default_tap_mask_32_lp = 32'hA600_0000;

    // One Galois step for a 32-bit register: shift right, fold the
    // shifted-out bit back in through the feedback mask.
    function automatic logic [31:0] lfsr_step_32(input logic [31:0] x,
                                                 input logic [31:0] mask);
        return (x >> 1) ^ (x[0] ? mask : 32'h0);
    endfunction

endpackage

// File: rtl/bsg_lfsr_checker_if.sv
// Valid/yumi word stream feeding the LFSR checker.
interface bsg_lfsr_checker_if #(
    parameter int width_p = 32
);
    logic               v_i;
    logic [width_p-1:0] data_i;
    logic               yumi_o;

    modport master (output v_i, output data_i, input  yumi_o);
    modport slave  (input  v_i, input  data_i, output yumi_o);
endinterface

// File: rtl/bsg_lfsr_checker_step.sv
// Combinational single step of a Galois LFSR: next(x) = (x >> 1) ^ (x[0] ? mask : 0).
module bsg_lfsr_checker_step
    import bsg_lfsr_checker_pkg::*;
#(
    parameter int                 width_p    = 32,
    parameter logic [width_p-1:0] tap_mask_p = width_p'(default_tap_mask_32_lp)
) (
    input  logic [width_p-1:0] x_i,
    output logic [width_p-1:0] next_o
);

    generate
        if (width_p == 32) begin : g_w32
            assign next_o = lfsr_step_32(x_i, tap_mask_p);
        end else begin : g_generic
            assign next_o = (x_i >> 1) ^ (x_i[0] ? tap_mask_p : '0);
        end
    endgenerate

endmodule

// File: rtl/bsg_lfsr_checker.sv
// Self-seeding checker for a Galois LFSR word stream: seeds from the first
// non-zero word, predicts every following word, counts mismatches and words,
// and reports lock after a run of consecutive matches.
module bsg_lfsr_checker
    import bsg_lfsr_checker_pkg::*;
#(
    parameter int                 width_p          = 32,
    parameter logic [width_p-1:0] tap_mask_p       = width_p'(default_tap_mask_32_lp),
    parameter int                 lock_threshold_p = 4,
    parameter int                 cnt_width_p      = 16,
    parameter bit                 resync_on_err_p  = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n_i,
    input  logic                   clear_i,
    bsg_lfsr_checker_if.slave      in_if,
    output logic                   locked_o,
    output logic                   err_v_o,
    output logic [width_p-1:0]     err_exp_o,
    output logic [cnt_width_p-1:0] err_cnt_o,
    output logic [cnt_width_p-1:0] word_cnt_o
);

    // match_run only needs to count up to the threshold, where it saturates.
    localparam int run_w_lp = $clog2(lock_threshold_p + 1);

    state_e                 state_reg,    state_next;
    logic [width_p-1:0]     exp_reg,      exp_next;
    logic [run_w_lp-1:0]    match_run_reg, match_run_next;
    logic                   locked_reg,   locked_next;
    logic                   err_v_reg,    err_v_next;
    logic [width_p-1:0]     err_exp_reg,  err_exp_next;
    logic [cnt_width_p-1:0] err_cnt_reg,  err_cnt_next;
    logic [cnt_width_p-1:0] word_cnt_reg, word_cnt_next;

    logic [width_p-1:0]     data_step;
    logic [width_p-1:0]     exp_step;
    logic                   accept;

    // Seed path: prediction for the word after a freshly accepted seed.
    bsg_lfsr_checker_step #(.width_p(width_p), .tap_mask_p(tap_mask_p)) u_step_data (
        .x_i    (in_if.data_i),
        .next_o (data_step)
    );

    // Check path: advance the running prediction.
    bsg_lfsr_checker_step #(.width_p(width_p), .tap_mask_p(tap_mask_p)) u_step_exp (
        .x_i    (exp_reg),
        .next_o (exp_step)
    );

    // Always ready, except that a clear swallows the cycle.
    assign accept       = in_if.v_i & ~clear_i;
    assign in_if.yumi_o = accept;

    // Next-state and output computation; clear behaves like a synchronous reset.
    always_comb begin
        state_next     = state_reg;
        exp_next       = exp_reg;
        match_run_next = match_run_reg;
        locked_next    = locked_reg;
        err_v_next     = 1'b0;
        err_exp_next   = err_exp_reg;
        err_cnt_next   = err_cnt_reg;
        word_cnt_next  = word_cnt_reg;

        if (clear_i) begin
            state_next     = SEED;
            exp_next       = '0;
            match_run_next = '0;
            locked_next    = 1'b0;
            err_exp_next   = '0;
            err_cnt_next   = '0;
            word_cnt_next  = '0;
        end else if (accept) begin
            word_cnt_next = word_cnt_reg + cnt_width_p'(1);
            unique case (state_reg)
                SEED: begin
                    if (in_if.data_i != '0) begin
                        exp_next       = data_step;
                        match_run_next = '0;
                        state_next     = CHECK;
                    end else begin
                        // All-zero is the one state a Galois LFSR can never reach.
                        err_v_next = 1'b1;
                        if (err_cnt_reg != '1) err_cnt_next = err_cnt_reg + cnt_width_p'(1);
                    end
                end
                CHECK: begin
                    if (in_if.data_i == exp_reg) begin
                        exp_next = exp_step;
                        if (int'(match_run_reg) < lock_threshold_p)
                            match_run_next = match_run_reg + run_w_lp'(1);
                        if (int'(match_run_reg) + 1 >= lock_threshold_p)
                            locked_next = 1'b1;
                    end else begin
                        err_v_next     = 1'b1;
                        err_exp_next   = exp_reg;
                        locked_next    = 1'b0;
                        match_run_next = '0;
                        if (err_cnt_reg != '1) err_cnt_next = err_cnt_reg + cnt_width_p'(1);
                        if (resync_on_err_p) state_next = SEED;
                        else                 exp_next   = exp_step;
                    end
                end
                default: state_next = SEED;
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg     <= SEED;
            exp_reg       <= '0;
            match_run_reg <= '0;
            locked_reg    <= 1'b0;
            err_v_reg     <= 1'b0;
            err_exp_reg   <= '0;
            err_cnt_reg   <= '0;
            word_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            exp_reg       <= exp_next;
            match_run_reg <= match_run_next;
            locked_reg    <= locked_next;
            err_v_reg     <= err_v_next;
            err_exp_reg   <= err_exp_next;
            err_cnt_reg   <= err_cnt_next;
            word_cnt_reg  <= word_cnt_next;
        end
    end

    assign locked_o   = locked_reg;
    assign err_v_o    = err_v_reg;
    assign err_exp_o  = err_exp_reg;
    assign err_cnt_o  = err_cnt_reg;
    assign word_cnt_o = word_cnt_reg;

endmodule

// File: tb/tb_bsg_lfsr_checker.sv
// Directed bench for bsg_lfsr_checker: default instance (resync on error,
// 16-bit counters) and a 4-bit-counter instance that keeps predicting on error.
module tb_bsg_lfsr_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic a_clear, b_clear;

    bsg_lfsr_checker_if #(.width_p(32)) a_if ();
    bsg_lfsr_checker_if #(.width_p(32)) b_if ();

    logic        a_locked, a_err_v;
    logic [31:0] a_err_exp;
    logic [15:0] a_err_cnt, a_word_cnt;

    logic        b_locked, b_err_v;
    logic [31:0] b_err_exp;
    logic [3:0]  b_err_cnt, b_word_cnt;

    bsg_lfsr_checker dut_a (
        .clk        (clk),
        .reset_n_i  (reset_n),
        .clear_i    (a_clear),
        .in_if      (a_if.slave),
        .locked_o   (a_locked),
        .err_v_o    (a_err_v),
        .err_exp_o  (a_err_exp),
        .err_cnt_o  (a_err_cnt),
        .word_cnt_o (a_word_cnt)
    );

    bsg_lfsr_checker #(.cnt_width_p(4), .resync_on_err_p(1'b0)) dut_b (
        .clk        (clk),
        .reset_n_i  (reset_n),
        .clear_i    (b_clear),
        .in_if      (b_if.slave),
        .locked_o   (b_locked),
        .err_v_o    (b_err_v),
        .err_exp_o  (b_err_exp),
        .err_cnt_o  (b_err_cnt),
        .word_cnt_o (b_word_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // One accepted word on instance A; outputs are sampled 1 ns after the edge.
    task automatic a_word(input logic [31:0] d);
        a_if.v_i    = 1'b1;
        a_if.data_i = d;
        @(posedge clk); #1;
        a_if.v_i    = 1'b0;
    endtask

    task automatic b_word(input logic [31:0] d);
        b_if.v_i    = 1'b1;
        b_if.data_i = d;
        @(posedge clk); #1;
        b_if.v_i    = 1'b0;
    endtask

    task automatic a_idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Clear with v_i high: the word must not be consumed.
    task automatic a_do_clear(input string tag);
        a_clear     = 1'b1;
        a_if.v_i    = 1'b1;
        a_if.data_i = 32'h0000_0001;
        #1;
        check_val({tag, "_yumi_during_clear"}, 64'(a_if.yumi_o), 64'd0);
        @(posedge clk); #1;
        a_clear  = 1'b0;
        a_if.v_i = 1'b0;
    endtask

    logic [31:0] bubble_words [7] = '{32'h0000_0001, 32'hA600_0000, 32'h5300_0000,
                                      32'h2980_0000, 32'h14C0_0000, 32'h0A60_0000,
                                      32'h0530_0000};

    initial begin
        reset_n     = 1'b0;
        a_clear     = 1'b0;
        b_clear     = 1'b0;
        a_if.v_i    = 1'b0;
        a_if.data_i = '0;
        b_if.v_i    = 1'b0;
        b_if.data_i = '0;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_locked",   64'(a_locked),   64'd0);
        check_val("rst_err_v",    64'(a_err_v),    64'd0);
        check_val("rst_err_exp",  64'(a_err_exp),  64'd0);
        check_val("rst_err_cnt",  64'(a_err_cnt),  64'd0);
        check_val("rst_word_cnt", 64'(a_word_cnt), 64'd0);
        reset_n = 1'b1;
        a_idle(1);

        // Seed and lock
        a_word(32'h0000_0001);
        check_val("seed_no_err", 64'(a_err_v), 64'd0);
        a_word(32'hA600_0000);
        a_word(32'h5300_0000);
        a_word(32'h2980_0000);
        check_val("lock_pre",      64'(a_locked),   64'd0);
        a_word(32'h14C0_0000);
        check_val("lock_locked",   64'(a_locked),   64'd1);
        check_val("lock_err_cnt",  64'(a_err_cnt),  64'd0);
        check_val("lock_word_cnt", 64'(a_word_cnt), 64'd5);

        // Mismatch with resync
        a_word(32'h0A60_0001);
        check_val("mis_err_v",   64'(a_err_v),   64'd1);
        check_val("mis_err_exp", 64'(a_err_exp), 64'h0A60_0000);
        check_val("mis_locked",  64'(a_locked),  64'd0);
        check_val("mis_err_cnt", 64'(a_err_cnt), 64'd1);
        a_idle(1);
        check_val("mis_pulse_end", 64'(a_err_v), 64'd0);
        a_word(32'h0A60_0000);
        check_val("reseed_no_err", 64'(a_err_v), 64'd0);
        a_word(32'h0530_0000);
        a_word(32'h0298_0000);
        a_word(32'h014C_0000);
        check_val("relock_pre",      64'(a_locked),   64'd0);
        a_word(32'h00A6_0000);
        check_val("relock_locked",   64'(a_locked),   64'd1);
        check_val("relock_err_cnt",  64'(a_err_cnt),  64'd1);
        check_val("relock_word_cnt", 64'(a_word_cnt), 64'd11);

        // Zero seeds
        a_do_clear("zero");
        check_val("clr_word_cnt", 64'(a_word_cnt), 64'd0);
        check_val("clr_err_cnt",  64'(a_err_cnt),  64'd0);
        check_val("clr_locked",   64'(a_locked),   64'd0);
        for (int i = 0; i < 3; i++) begin
            a_word(32'h0000_0000);
            check_val($sformatf("zero%0d_err_v", i), 64'(a_err_v), 64'd1);
        end
        check_val("zero_err_cnt", 64'(a_err_cnt), 64'd3);
        check_val("zero_locked",  64'(a_locked),  64'd0);
        a_word(32'h0000_0001);
        check_val("zero_then_seed", 64'(a_err_v), 64'd0);
        a_word(32'hA600_0000);
        check_val("zero_then_match", 64'(a_err_v),   64'd0);
        check_val("zero_err_hold",   64'(a_err_cnt), 64'd3);

        // Bubbles between words
        a_do_clear("bub");
        for (int i = 0; i < 7; i++) begin
            a_idle($urandom_range(0, 3));
            if (i == 0) begin
                a_if.v_i    = 1'b1;
                a_if.data_i = bubble_words[i];
                #1;
                check_val("bub_yumi", 64'(a_if.yumi_o), 64'd1);
                @(posedge clk); #1;
                a_if.v_i = 1'b0;
            end else begin
                a_word(bubble_words[i]);
            end
        end
        a_idle(2);
        check_val("bub_locked",   64'(a_locked),   64'd1);
        check_val("bub_err_cnt",  64'(a_err_cnt),  64'd0);
        check_val("bub_word_cnt", 64'(a_word_cnt), 64'd7);

        // Async reset mid-stream, between edges
        #2;
        reset_n = 1'b0;
        #1;
        check_val("arst_locked",   64'(a_locked),   64'd0);
        check_val("arst_word_cnt", 64'(a_word_cnt), 64'd0);
        check_val("arst_err_cnt",  64'(a_err_cnt),  64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        a_word(32'h1234_5678);
        a_word(32'h091A_2B3C);
        check_val("arst_seed_err_v",  64'(a_err_v),    64'd0);
        check_val("arst_seed_errcnt", 64'(a_err_cnt),  64'd0);
        check_val("arst_seed_words",  64'(a_word_cnt), 64'd2);

        // Saturation on the 4-bit instance, no resync
        b_word(32'h0000_0001);
        for (int i = 0; i < 20; i++) begin
            b_word(32'h0000_0000);
            if (i == 0) check_val("sat_exp0", 64'(b_err_exp), 64'hA600_0000);
            if (i == 1) check_val("sat_exp1", 64'(b_err_exp), 64'h5300_0000);
        end
        check_val("sat_err_cnt",  64'(b_err_cnt),  64'hF);
        check_val("sat_word_cnt", 64'(b_word_cnt), 64'd5);
        b_clear     = 1'b1;
        b_if.v_i    = 1'b1;
        b_if.data_i = 32'h0000_0001;
        #1;
        check_val("sat_clr_yumi", 64'(b_if.yumi_o), 64'd0);
        @(posedge clk); #1;
        b_clear  = 1'b0;
        b_if.v_i = 1'b0;
        check_val("sat_clr_err_cnt",  64'(b_err_cnt),  64'd0);
        check_val("sat_clr_word_cnt", 64'(b_word_cnt), 64'd0);
        check_val("sat_clr_err_exp",  64'(b_err_exp),  64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
